// File: rtl/alu32_op_issue.sv
// Issue stage for a 32-bit gate-level ALU: latches a request, enables the unit
// selected by the opcode for SETTLE_CYCLES, then captures and holds the result.
module alu32_op_issue #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        InValid,
    output logic        InReady,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] UnitA,
    output logic [31:0] UnitB,
    output logic [5:0]  En,
    input  logic [31:0] UnitOut,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] Result,
    output logic        Zero,
    output logic        ErrOp
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    function automatic logic [5:0] op_onehot(input logic [2:0] op);
        logic [5:0] oh;
        case (op)
            3'd0:    oh = 6'b000001;
            3'd1:    oh = 6'b000010;
            3'd2:    oh = 6'b000100;
            3'd3:    oh = 6'b001000;
            3'd4:    oh = 6'b010000;
            3'd5:    oh = 6'b100000;
            default: oh = 6'b000000;
        endcase
        return oh;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= 3'd5);
    endfunction

    logic [1:0]  state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [31:0] opa_r, opa_s;
    logic [31:0] opb_r, opb_s;
    logic [31:0] res_r, res_s;
    logic        zero_r, zero_s;
    logic        err_r, err_s;
    logic [5:0]  en_r, en_s;
    logic        vld_r, vld_s;
    logic        rdy_r;

    // Next-state and datapath update for the IDLE/EXEC/DONE sequence.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        opa_s   = opa_r;
        opb_s   = opb_r;
        res_s   = res_r;
        zero_s  = zero_r;
        err_s   = err_r;
        en_s    = en_r;
        vld_s   = vld_r;
        case (state_r)
            ST_IDLE: begin
                if (InValid) begin
                    opa_s = A;
                    opb_s = B;
                    if (op_legal(Op)) begin
                        cnt_s   = SETTLE_LOAD;
                        en_s    = op_onehot(Op);
                        state_s = ST_EXEC;
                    end else begin
                        res_s   = 32'd0;
                        zero_s  = 1'b1;
                        err_s   = 1'b1;
                        vld_s   = 1'b1;
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // A count of 0 can only come from an out-of-range parameter; capture rather than wrap.
                if (cnt_r <= 4'd1) begin
                    res_s   = UnitOut;
                    zero_s  = (UnitOut == 32'd0);
                    err_s   = 1'b0;
                    en_s    = 6'b000000;
                    vld_s   = 1'b1;
                    cnt_s   = 4'd0;
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                if (OutReady) begin
                    vld_s   = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
                en_s    = 6'b000000;
                vld_s   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            opa_r   <= 32'd0;
            opb_r   <= 32'd0;
            res_r   <= 32'd0;
            zero_r  <= 1'b1;
            err_r   <= 1'b0;
            en_r    <= 6'b000000;
            vld_r   <= 1'b0;
            rdy_r   <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            opa_r   <= opa_s;
            opb_r   <= opb_s;
            res_r   <= res_s;
            zero_r  <= zero_s;
            err_r   <= err_s;
            en_r    <= en_s;
            vld_r   <= vld_s;
            rdy_r   <= (state_s == ST_IDLE);
        end
    end

    assign InReady  = rdy_r;
    assign UnitA    = opa_r;
    assign UnitB    = opb_r;
    assign En       = en_r;
    assign OutValid = vld_r;
    assign Result   = res_r;
    assign Zero     = zero_r;
    assign ErrOp    = err_r;

endmodule

// File: tb/tb_alu32_op_issue.sv
// Scoreboard bench for alu32_op_issue: a gate-unit model closes the loop, a
// driver pushes expectations and a negedge monitor checks every result.
module tb_alu32_op_issue;

    localparam int S = 3;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        InValid = 1'b0;
    logic        OutReady = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        InReady, OutValid, Zero, ErrOp;
    logic [31:0] UnitA, UnitB, Result, UnitOut;
    logic [5:0]  En;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        err;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   hold_lo = 0;

    alu32_op_issue #(.SETTLE_CYCLES(S)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady),
        .Op(Op), .A(A), .B(B), .UnitA(UnitA), .UnitB(UnitB), .En(En),
        .UnitOut(UnitOut), .OutValid(OutValid), .OutReady(OutReady),
        .Result(Result), .Zero(Zero), .ErrOp(ErrOp)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return a ^ b;
            3'd4:    return a + b;
            3'd5:    return a - b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [5:0] exp_en(input logic [2:0] op);
        logic [5:0] one;
        one = 6'd1;
        return (op < 3'd6) ? (one << op) : 6'd0;
    endfunction

    // Gate units: each enabled unit drives its function, disabled ones drive 0.
    always_comb begin
        UnitOut = 32'd0;
        for (int n = 0; n < 6; n++) begin
            if (En[n]) UnitOut = UnitOut | alu_fn(3'(n), UnitA, UnitB);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Called #1 after a rising edge; scrambles inputs while the block is busy.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   w = 0;
        while (InReady !== 1'b1 && w < 100) begin
            Op = 3'($urandom_range(0, 7));
            A = $urandom;
            B = $urandom;
            InValid = 1'($urandom_range(0, 1));
            @(posedge Clk); #1;
            w++;
        end
        if (w >= 100) begin
            chk("issue_wait_timeout", 32'd0, 32'd1);
            InValid = 1'b0;
            return;
        end
        InValid = 1'b1;
        Op = op;
        A = a;
        B = b;
        e.op = op;
        e.a = a;
        e.b = b;
        e.res = alu_fn(op, a, b);
        e.zero = (e.res == 32'd0);
        e.err = (op > 3'd5);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(posedge Clk); #1;
        InValid = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            if (InReady === 1'b1) begin
                InValid = 1'b0;
            end else begin
                InValid = 1'($urandom_range(0, 1));
                Op = 3'($urandom_range(0, 7));
                A = $urandom;
                B = $urandom;
            end
            @(posedge Clk); #1;
        end
        InValid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            gap(1);
            w++;
        end
        if (w >= 200) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Consumer back-pressure: random, or forced low for a requested stretch.
    initial begin
        forever begin
            @(posedge Clk); #2;
            if (hold_lo > 0) begin
                OutReady = 1'b0;
                hold_lo--;
            end else begin
                OutReady = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Monitor: checks the in-flight transaction against the queue front.
    initial begin
        logic pv;
        int   enc;
        int   want;
        exp_t cur;
        pv = 1'b0;
        enc = 0;
        forever begin
            @(negedge Clk);
            if (!Rst_n) begin
                pv = 1'b0;
                enc = 0;
            end else if (exp_q.size() == 0 || cyc < exp_q[0].acc) begin
                chk("idle_en", 32'(En), 32'd0);
                chk("idle_outvalid", 32'(OutValid), 32'd0);
                pv = 1'b0;
                enc = 0;
            end else begin
                cur = exp_q[0];
                want = cur.err ? 0 : S;
                chk("unit_a", UnitA, cur.a);
                chk("unit_b", UnitB, cur.b);
                if (En != 6'd0) begin
                    chk("en_onehot", 32'(En), 32'(exp_en(cur.op)));
                    enc++;
                end
                if (OutValid) begin
                    if (!pv) begin
                        chk("latency", 32'(cyc - cur.acc), 32'(want));
                        chk("en_cycles", 32'(enc), 32'(want));
                    end
                    chk("result", Result, cur.res);
                    chk("zero", 32'(Zero), 32'(cur.zero));
                    chk("errop", 32'(ErrOp), 32'(cur.err));
                    chk("done_inready", 32'(InReady), 32'd0);
                    chk("done_en", 32'(En), 32'd0);
                    if (OutReady) void'(exp_q.pop_front());
                end else begin
                    chk("busy_inready", 32'(InReady), 32'd0);
                end
                pv = OutValid;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_inready", 32'(InReady), 32'd1);
        chk("rst_outvalid", 32'(OutValid), 32'd0);
        chk("rst_en", 32'(En), 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_zero", 32'(Zero), 32'd1);
        chk("rst_errop", 32'(ErrOp), 32'd0);
        chk("rst_unit_a", UnitA, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); #1;

        issue(3'd4, 32'h00000005, 32'h00000003);
        drain();
        issue(3'd0, 32'hFFFFFFFF, 32'h0000ABCD);
        drain();
        issue(3'd7, 32'h12345678, 32'h9ABCDEF0);
        drain();
        issue(3'd6, 32'hDEADBEEF, 32'h00000001);
        drain();
        hold_lo = S + 6;
        issue(3'd1, 32'hF0F0F0F0, 32'hFF00FF00);
        drain();
        issue(3'd5, 32'h00000007, 32'h00000007);
        drain();

        // Abort mid-EXEC with reset asserted between edges.
        issue(3'd2, 32'h0F0F0000, 32'h000000F0);
        @(negedge Clk); #2;
        Rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_en", 32'(En), 32'd0);
        chk("abort_outvalid", 32'(OutValid), 32'd0);
        chk("abort_inready", 32'(InReady), 32'd1);
        chk("abort_result", Result, 32'd0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        gap(2 * S + 4);
        issue(3'd3, 32'hAAAA5555, 32'hFFFF0000);
        drain();

        for (int k = 0; k < 150; k++) begin
            issue(3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            gap($urandom_range(0, 4));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu32_op_issue.md
ALU32_OP_ISSUE -- requirements
Module: alu32_op_issue

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, cycles En is held before result capture (legal 1..15).
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port InValid  input  1  request valid.
REQ-005 SHALL have port InReady  output  1  block can accept a request.
REQ-006 SHALL have port Op  input  3  opcode: 0 NOT A, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB, 6/7 illegal.
REQ-007 SHALL have port A  input  32  operand A.
REQ-008 SHALL have port B  input  32  operand B.
REQ-009 SHALL have port UnitA  output  32  registered operand A driven to all gate units.
REQ-010 SHALL have port UnitB  output  32  registered operand B driven to all gate units.
REQ-011 SHALL have port En  output  6  one-hot unit enables; bit n enables the unit for opcode n.
REQ-012 SHALL have port UnitOut  input  32  OR-combination of all unit outputs; disabled units contribute 0.
REQ-013 SHALL have port OutValid  output  1  result valid.
REQ-014 SHALL have port OutReady  input  1  consumer accepts result.
REQ-015 SHALL have port Result  output  32  captured result.
REQ-016 SHALL have port Zero  output  1  Result == 0.
REQ-017 SHALL have port ErrOp  output  1  current result is from an illegal opcode.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, EXEC, DONE.
REQ-019 IDLE SHALL drive InReady=1; InReady SHALL be 0 in EXEC and DONE.
REQ-020 On InValid & InReady with Op 0..5, SHALL latch A, B, Op into operand registers, load settle counter with SETTLE_CYCLES, and go to EXEC.
REQ-021 On InValid & InReady with Op 6/7, SHALL latch operands, set Result=0, Zero=1, ErrOp=1, go directly to DONE; En SHALL stay 0.
REQ-022 In EXEC, En SHALL equal one-hot of latched Op; En SHALL be 0 in IDLE and DONE.
REQ-023 In EXEC the counter SHALL decrement each cycle; in the cycle it equals 1, the edge SHALL capture UnitOut into Result, Zero=(UnitOut==0), ErrOp=0, and go to DONE.
REQ-024 Latency: request accepted at edge t, legal op -> OutValid first high in the cycle after edge t+SETTLE_CYCLES (SETTLE_CYCLES+1 cycles after acceptance); illegal op -> 1 cycle.
REQ-025 DONE SHALL drive OutValid=1 and hold Result, Zero, ErrOp stable until OutReady is sampled high.
REQ-026 On OutValid & OutReady SHALL return to IDLE; no new request accepted in that same cycle.
REQ-027 UnitA/UnitB SHALL always reflect operand registers; they SHALL change only at an accepting edge.
REQ-028 Changes on A, B, Op, InValid while not in IDLE SHALL be ignored.
REQ-029 UnitOut SHALL be sampled only at the capture edge; its value at other times SHALL not affect state.
REQ-030 OutReady high while not in DONE SHALL have no effect.
REQ-031 Minimum spacing between accepted requests SHALL be SETTLE_CYCLES+2 cycles (legal) / 2 cycles (illegal).

Reset
REQ-032 Rst_n low SHALL immediately, independent of Clk, force state IDLE, counter 0, operand registers 0, Result 0, Zero 1, ErrOp 0, En 0, OutValid 0; InReady SHALL be 1 once the state is IDLE.
REQ-033 Reset during EXEC or DONE SHALL abort the operation; no OutValid SHALL be produced for it after release.
REQ-034 After Rst_n deasserts, the first request SHALL be accepted on the first rising edge with InValid high.

Verification
REQ-035 SETTLE_CYCLES=1, Op=4 (ADD), A=0x00000005, B=0x00000003, model UnitOut=A+B when En[4] -> En=6'b010000 for exactly 1 cycle, OutValid 2 cycles after accept, Result=0x00000008, Zero=0, ErrOp=0.
REQ-036 Op=0 (NOT), A=0xFFFFFFFF, UnitOut=~A & En[0] replicated -> Result=0x00000000, Zero=1, ErrOp=0.
REQ-037 Op=7, A=0x12345678 -> En stays 0, OutValid 1 cycle after accept, Result=0, Zero=1, ErrOp=1.
REQ-038 SETTLE_CYCLES=3, Op=1 (AND), A=0xF0F0F0F0, B=0xFF00FF00, OutReady held low 5 cycles -> En[1] high exactly 3 cycles, Result=0xF000F000 held stable with OutValid=1 and InReady=0 until OutReady=1, then IDLE.
REQ-039 Change A/B/Op every cycle during EXEC -> Result reflects only the values latched at acceptance.
REQ-040 Assert Rst_n=0 mid-EXEC between clock edges -> En, OutValid cleared at once, InReady=1 after release, no stale OutValid afterwards.
